// File: rtl/display_pkg.sv
// Shared constants, the digit-select helper and the load FSM state type for
// the hex scan driver.
package display_pkg;

  localparam int DEFAULT_NUM_DIGITS = 4;
  localparam int DEFAULT_SCAN_DIV   = 50000;
  localparam int NIBBLE_W           = 4;
  localparam int MAX_DIGITS         = 8;

  // Two-state load tracker: IDLE when no value waits for commit, PENDING
  // while the shadow register holds a captured value not yet shown.
  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } load_state_e;

  // One-hot select for a digit index. The result is MAX_DIGITS wide and
  // callers truncate it to their own digit count.
  function automatic logic [MAX_DIGITS-1:0] onehot(input logic [2:0] idx);
    logic [MAX_DIGITS-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Dwell counter for the digit scan: counts 0..SCAN_DIV-1 and emits a
// one-cycle advance pulse on the last count of each dwell period.
module scan_prescaler #(
  parameter int SCAN_DIV = 4
) (
  input  logic Clock,
  input  logic Reset,
  output logic advance
);

  localparam int TICK_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SCAN_DIV - 1);

  logic [TICK_W-1:0] tick_q;
  logic [TICK_W-1:0] tick_d;

  // Next tick value: wrap to zero at the end of the dwell, otherwise count up.
  always_comb begin
    advance = (tick_q == TICK_LAST);
    tick_d  = advance ? '0 : tick_q + 1'b1;
  end

  // Tick register with synchronous reset.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      tick_q <= '0;
    end else begin
      tick_q <= tick_d;
    end
  end

endmodule

// File: rtl/hex_scan_driver.sv
// Time-multiplexed hex display driver. A load strobe captures a new
// NUM_DIGITS-nibble value into a shadow register; it is committed to the
// displayed (active) value only at a frame boundary so a frame never mixes
// old and new nibbles. A load landing on the boundary edge itself goes
// straight into the active register.
// Build option: define HEX_BLANK_EN to blank leading-zero digits (digit 0 is
// always shown).
module hex_scan_driver
  import display_pkg::*;
#(
  parameter int NUM_DIGITS = DEFAULT_NUM_DIGITS,
  parameter int SCAN_DIV   = DEFAULT_SCAN_DIV
) (
  input  logic                         Clock,
  input  logic                         Reset,
  input  logic [NIBBLE_W*NUM_DIGITS-1:0] value,
  input  logic                         load,
  output logic                         busy,
  output logic [NIBBLE_W-1:0]          digit,
  output logic [NUM_DIGITS-1:0]        digit_en,
  output logic                         frame_done
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam int VAL_W = NIBBLE_W * NUM_DIGITS;

  logic              advance;
  logic              frame_wrap;

  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              frame_done_q, frame_done_d;
  load_state_e       state_q, state_d;
  logic [VAL_W-1:0]  shadow_q, shadow_d;
  logic [VAL_W-1:0]  active_q, active_d;

  scan_prescaler #(
    .SCAN_DIV (SCAN_DIV)
  ) u_prescaler (
    .Clock   (Clock),
    .Reset   (Reset),
    .advance (advance)
  );

  // Digit index stepping; the wrap from the last digit back to zero is the frame boundary.
  always_comb begin
    frame_wrap   = advance && (idx_q == IDX_LAST);
    idx_d        = idx_q;
    if (advance) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
    frame_done_d = frame_wrap;
  end

  // Load FSM next state: capture into shadow, commit at the boundary, and let a
  // load on the boundary edge bypass the shadow entirely.
  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    active_d = active_q;
    case (state_q)
      IDLE: begin
        if (load) begin
          if (frame_wrap) begin
            active_d = value;
          end else begin
            shadow_d = value;
            state_d  = PENDING;
          end
        end
      end
      PENDING: begin
        if (frame_wrap) begin
          active_d = load ? value : shadow_q;
          state_d  = IDLE;
        end else if (load) begin
          shadow_d = value;
        end
      end
    endcase
  end

  // All state registers, cleared together by the synchronous reset.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      idx_q        <= '0;
      frame_done_q <= 1'b0;
      state_q      <= IDLE;
      shadow_q     <= '0;
      active_q     <= '0;
    end else begin
      idx_q        <= idx_d;
      frame_done_q <= frame_done_d;
      state_q      <= state_d;
      shadow_q     <= shadow_d;
      active_q     <= active_d;
    end
  end

  // Outputs decoded purely from registers: nibble mux, digit select and status.
  always_comb begin
    logic blank;
`ifdef HEX_BLANK_EN
    logic zeros_above;
`endif
    busy       = (state_q == PENDING);
    frame_done = frame_done_q;
    digit      = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_q == IDX_W'(k)) begin
        digit = active_q[k*NIBBLE_W +: NIBBLE_W];
      end
    end
    blank = 1'b0;
`ifdef HEX_BLANK_EN
    zeros_above = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      zeros_above = zeros_above && (active_q[k*NIBBLE_W +: NIBBLE_W] == '0);
      if ((idx_q == IDX_W'(k)) && zeros_above) begin
        blank = 1'b1;
      end
    end
`endif
    digit_en = blank ? '0 : NUM_DIGITS'(onehot(3'(idx_q)));
  end

endmodule

// File: tb/tb_hex_scan_driver.sv
// Self-checking bench for hex_scan_driver with NUM_DIGITS=4, SCAN_DIV=4
// (16-cycle frames). Expected outputs come from a frame-arithmetic model.
module tb_hex_scan_driver;

  localparam int N     = 4;
  localparam int S     = 4;
  localparam int FRAME = N * S;

  logic        Clock;
  logic        Reset;
  logic [15:0] value;
  logic        load;
  logic        busy;
  logic [3:0]  digit;
  logic [3:0]  digit_en;
  logic        frame_done;

  int total;
  int bad;

  // Reference model: cycle count since reset release plus value bookkeeping.
  int          m_cyc;
  logic [15:0] m_active;
  logic [15:0] m_shadow;
  bit          m_pending;

  hex_scan_driver #(
    .NUM_DIGITS (N),
    .SCAN_DIV   (S)
  ) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .value      (value),
    .load       (load),
    .busy       (busy),
    .digit      (digit),
    .digit_en   (digit_en),
    .frame_done (frame_done)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  function automatic int exp_slot();
    return (m_cyc / S) % N;
  endfunction

  function automatic logic [3:0] exp_digit();
    return m_active[4*exp_slot() +: 4];
  endfunction

  function automatic logic [3:0] exp_en();
    int i;
    i = exp_slot();
`ifdef HEX_BLANK_EN
    if (i > 0 && (m_active >> (4*i)) == 16'h0000) return 4'b0000;
`endif
    return 4'(1 << i);
  endfunction

  function automatic logic exp_fd();
    return (m_cyc > 0) && (m_cyc % FRAME == 0);
  endfunction

  task automatic do_reset();
    Reset = 1'b1;
    load  = 1'b0;
    value = 16'h0000;
    @(posedge Clock);
    m_cyc     = 0;
    m_active  = 16'h0000;
    m_shadow  = 16'h0000;
    m_pending = 1'b0;
    #1;
    Reset = 1'b0;
  endtask

  task automatic step(input bit ld, input logic [15:0] v);
    load  = ld;
    value = v;
    @(posedge Clock);
    if (m_cyc % FRAME == FRAME - 1) begin
      if (ld) m_active = v;
      else if (m_pending) m_active = m_shadow;
      m_pending = 1'b0;
    end else if (ld) begin
      m_shadow  = v;
      m_pending = 1'b1;
    end
    m_cyc++;
    #1;
    load = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (digit !== 4'h0) begin bad++; $display("[TB] FAIL reset_digit got=%h want=0", digit); end
    total++; if (digit_en !== 4'b0001) begin bad++; $display("[TB] FAIL reset_en got=%b want=0001", digit_en); end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy got=%b want=0", busy); end
    total++; if (frame_done !== 1'b0) begin bad++; $display("[TB] FAIL reset_fd got=%b want=0", frame_done); end
  endtask

  task automatic test_scan_idle();
    do_reset();
    for (int c = 0; c < 40; c++) begin
      total++; if (digit_en !== exp_en()) begin bad++; $display("[TB] FAIL idle_en cyc=%0d got=%b want=%b", m_cyc, digit_en, exp_en()); end
      total++; if (digit !== 4'h0) begin bad++; $display("[TB] FAIL idle_digit cyc=%0d got=%h want=0", m_cyc, digit); end
      total++; if (frame_done !== exp_fd()) begin bad++; $display("[TB] FAIL idle_fd cyc=%0d got=%b want=%b", m_cyc, frame_done, exp_fd()); end
      step(1'b0, 16'h0000);
    end
  endtask

  task automatic test_load();
    do_reset();
    while (m_cyc < 5) step(1'b0, 16'h0000);
    step(1'b1, 16'h1A3F);
    while (m_cyc < 36) begin
      total++; if (busy !== m_pending) begin bad++; $display("[TB] FAIL load_busy cyc=%0d got=%b want=%b", m_cyc, busy, m_pending); end
      total++; if (digit !== exp_digit()) begin bad++; $display("[TB] FAIL load_digit cyc=%0d got=%h want=%h", m_cyc, digit, exp_digit()); end
      if (m_cyc == 16) begin
        total++; if (digit !== 4'hF) begin bad++; $display("[TB] FAIL load_first cyc=16 got=%h want=F", digit); end
      end
      if (m_cyc == 28) begin
        total++; if (digit !== 4'h1) begin bad++; $display("[TB] FAIL load_msd cyc=28 got=%h want=1", digit); end
      end
      step(1'b0, 16'h0000);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    while (m_cyc < 32) begin
      if (m_cyc >= 16) begin
        total++; if (digit !== 4'h2) begin bad++; $display("[TB] FAIL b2b_digit cyc=%0d got=%h want=2", m_cyc, digit); end
      end
      total++; if (busy !== m_pending) begin bad++; $display("[TB] FAIL b2b_busy cyc=%0d got=%b want=%b", m_cyc, busy, m_pending); end
      if (m_cyc == 3) step(1'b1, 16'h1111);
      else if (m_cyc == 9) step(1'b1, 16'h2222);
      else step(1'b0, 16'h0000);
    end
  endtask

  task automatic test_boundary_bypass();
    do_reset();
    while (m_cyc < 48) begin
      total++; if (busy !== m_pending) begin bad++; $display("[TB] FAIL byp_busy cyc=%0d got=%b want=%b", m_cyc, busy, m_pending); end
      total++; if (digit !== exp_digit()) begin bad++; $display("[TB] FAIL byp_digit cyc=%0d got=%h want=%h", m_cyc, digit, exp_digit()); end
      if (m_cyc < 32) begin
        total++; if (busy !== (m_cyc > 20 && m_cyc < 32)) begin bad++; $display("[TB] FAIL byp_busy_plan cyc=%0d got=%b", m_cyc, busy); end
      end
      if (m_cyc == 16) begin
        total++; if (digit !== 4'h5) begin bad++; $display("[TB] FAIL byp_first cyc=16 got=%h want=5", digit); end
      end
      if (m_cyc == 32) begin
        total++; if (digit !== 4'h6) begin bad++; $display("[TB] FAIL byp_over cyc=32 got=%h want=6", digit); end
      end
      if (m_cyc == 15) step(1'b1, 16'h00C5);
      else if (m_cyc == 20) step(1'b1, 16'h4444);
      else if (m_cyc == 31) step(1'b1, 16'h00C6);
      else step(1'b0, 16'h0000);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    while (m_cyc < 26) begin
      if (m_cyc == 2) step(1'b1, 16'hBEEF);
      else if (m_cyc == 20) step(1'b1, 16'h1234);
      else step(1'b0, 16'h0000);
    end
    total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL mid_pre_busy got=%b want=1", busy); end
    do_reset();
    total++; if (digit_en !== 4'b0001) begin bad++; $display("[TB] FAIL mid_en got=%b want=0001", digit_en); end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL mid_busy got=%b want=0", busy); end
    total++; if (frame_done !== 1'b0) begin bad++; $display("[TB] FAIL mid_fd got=%b want=0", frame_done); end
    while (m_cyc < 40) begin
      total++; if (digit !== 4'h0) begin bad++; $display("[TB] FAIL mid_digit cyc=%0d got=%h want=0", m_cyc, digit); end
      step(1'b0, 16'h0000);
    end
  endtask

`ifdef HEX_BLANK_EN
  task automatic test_blanking();
    do_reset();
    while (m_cyc < 48) begin
      if (m_cyc >= 16) begin
        total++; if (digit_en !== ((m_cyc % FRAME) < S ? 4'b0001 : 4'b0000)) begin bad++; $display("[TB] FAIL blank_en cyc=%0d got=%b", m_cyc, digit_en); end
      end
      if (m_cyc >= 16 && m_cyc < 32 && (m_cyc % FRAME) < S) begin
        total++; if (digit !== 4'h7) begin bad++; $display("[TB] FAIL blank_digit cyc=%0d got=%h want=7", m_cyc, digit); end
      end
      if (m_cyc == 15) step(1'b1, 16'h0007);
      else if (m_cyc == 31) step(1'b1, 16'h0000);
      else step(1'b0, 16'h0000);
    end
  endtask
`endif

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      total++; if (digit !== exp_digit()) begin bad++; $display("[TB] FAIL rnd_digit cyc=%0d got=%h want=%h", m_cyc, digit, exp_digit()); end
      total++; if (digit_en !== exp_en()) begin bad++; $display("[TB] FAIL rnd_en cyc=%0d got=%b want=%b", m_cyc, digit_en, exp_en()); end
      total++; if (busy !== m_pending) begin bad++; $display("[TB] FAIL rnd_busy cyc=%0d got=%b want=%b", m_cyc, busy, m_pending); end
      total++; if (frame_done !== exp_fd()) begin bad++; $display("[TB] FAIL rnd_fd cyc=%0d got=%b want=%b", m_cyc, frame_done, exp_fd()); end
      if ($urandom_range(0, 149) == 0) do_reset();
      else step($urandom_range(0, 5) == 0, 16'($urandom));
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    Reset = 1'b1;
    load  = 1'b0;
    value = 16'h0000;
    repeat (2) @(posedge Clock);
    #1;
    test_reset();
    test_scan_idle();
    test_load();
    test_back_to_back();
    test_boundary_bypass();
    test_reset_mid();
`ifdef HEX_BLANK_EN
    test_blanking();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
